// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared definitions for the sequenced control decoder.
//   Opcode constants, branch condition and FSM state enums, and the
//   branch-condition evaluation helper.
package ctrl_seq_pkg;

  localparam logic [4:0] OP_LDR   = 5'b01100;
  localparam logic [4:0] OP_STR   = 5'b01101;
  localparam logic [4:0] OP_NOP   = 5'b00110;
  localparam logic [2:0] BR_CLASS = 3'b010;

  typedef enum logic [1:0] {
    COND_AL = 2'b00,
    COND_EQ = 2'b01,
    COND_NE = 2'b10,
    COND_LT = 2'b11
  } cond_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    MEM  = 2'b10,
    DONE = 2'b11
  } ctrl_state_t;

  // Signed less-than is N xor V; carry is not used by any condition.
  function automatic logic cond_true(cond_t c, logic z, logic n, logic v);
    case (c)
      COND_AL: return 1'b1;
      COND_EQ: return z;
      COND_NE: return !z;
      default: return n ^ v;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: program/control bundle between ROM, ALU flags, fetch unit
//   and the write enables of reg_file/data_mem.
//   master: drives Start, Instruction, Flags; observes the strobes.
//   slave : the controller (ctrl_seq).
interface ctrl_seq_if #(
  parameter int IW = 9,
  parameter int TW = 3
);
  logic          Start;
  logic [IW-1:0] Instruction;
  logic [3:0]    Flags;       // {Z,N,C,V}
  logic [TW-1:0] PCTarg;
  logic          Jump;
  logic          Advance;
  logic          RegWrEn;
  logic          MemWrEn;
  logic          LoadInst;
  logic          Stall;
  logic          Busy;
  logic          Ack;

  modport master (
    output Start, Instruction, Flags,
    input  PCTarg, Jump, Advance, RegWrEn, MemWrEn, LoadInst, Stall, Busy, Ack
  );

  modport slave (
    input  Start, Instruction, Flags,
    output PCTarg, Jump, Advance, RegWrEn, MemWrEn, LoadInst, Stall, Busy, Ack
  );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: pure combinational opcode classifier.
//   instr_i   : instruction word
//   is_*_o    : instruction class flags (at most one set)
//   cond_o    : branch condition field
module ctrl_decode
  import ctrl_seq_pkg::*;
#(
  parameter int IW = 9
) (
  input  logic [IW-1:0] instr_i,
  output logic          is_ldr_o,
  output logic          is_str_o,
  output logic          is_br_o,
  output logic          is_halt_o,
  output logic          is_nop_o,
  output cond_t         cond_o
);

  logic [4:0] opcode;

  assign opcode    = instr_i[IW-1:IW-5];
  assign is_halt_o = (instr_i == '0);
  assign is_br_o   = (opcode[4:2] == BR_CLASS);
  assign is_ldr_o  = (opcode == OP_LDR);
  assign is_str_o  = (opcode == OP_STR);
  assign is_nop_o  = (opcode == OP_NOP);
  assign cond_o    = cond_t'(opcode[1:0]);

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: sequenced control decoder with fixed-latency memory stall.
//   Clk   : clock, rising edge
//   Reset : asynchronous, active-low
//   bus   : ctrl_seq_if slave (Start/Instruction/Flags in; strobes,
//           PCTarg, registered Busy/Ack out)
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | one instruction per cycle
// MEM   | load/store wait; counter counts down to the write cycle
// DONE  | program halted, Ack high until Start drops
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int IW      = 9,
  parameter int TW      = 3,
  parameter int MEM_LAT = 2
) (
  input  logic    Clk,
  input  logic    Reset,
  ctrl_seq_if.slave bus
);

  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (MEM_LAT > 0) ? CW'(MEM_LAT - 1) : '0;

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;

  logic  is_ldr, is_str, is_br, is_halt, is_nop;
  cond_t cond;
  logic  taken;

  logic jump, advance, reg_wr, mem_wr, load_inst, stall;

  logic unused_flag_c;
  assign unused_flag_c = bus.Flags[1];

  ctrl_decode #(.IW(IW)) u_decode (
    .instr_i   (bus.Instruction),
    .is_ldr_o  (is_ldr),
    .is_str_o  (is_str),
    .is_br_o   (is_br),
    .is_halt_o (is_halt),
    .is_nop_o  (is_nop),
    .cond_o    (cond)
  );

  assign taken = cond_true(cond, bus.Flags[3], bus.Flags[2], bus.Flags[0]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    jump      = 1'b0;
    advance   = 1'b0;
    reg_wr    = 1'b0;
    mem_wr    = 1'b0;
    load_inst = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) state_d = RUN;
      end
      RUN: begin
        if (is_halt) begin
          state_d = DONE;
        end else if (is_br) begin
          jump    = taken;
          advance = !taken;
        end else if (is_ldr || is_str) begin
          load_inst = is_ldr;
          if (MEM_LAT == 0) begin
            // zero-latency memory: this cycle is also the write cycle
            advance = 1'b1;
            reg_wr  = is_ldr;
            mem_wr  = is_str;
          end else begin
            stall   = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = MEM;
          end
        end else if (is_nop) begin
          advance = 1'b1;
        end else begin
          reg_wr  = 1'b1;
          advance = 1'b1;
        end
      end
      MEM: begin
        load_inst = is_ldr;
        if (cnt_q == '0) begin
          advance = 1'b1;
          reg_wr  = is_ldr;
          mem_wr  = is_str;
          state_d = RUN;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (!bus.Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Busy/Ack are registered from the next state so they track the state
  // register exactly, without a decode glitch.
  assign busy_d = (state_d == RUN) || (state_d == MEM);
  assign ack_d  = (state_d == DONE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  // PCTarg is a pass-through, but forced low during reset so the whole
  // output bundle is quiet while Reset is asserted.
  assign bus.PCTarg   = Reset ? bus.Instruction[TW-1:0] : '0;
  assign bus.Jump     = jump;
  assign bus.Advance  = advance;
  assign bus.RegWrEn  = reg_wr;
  assign bus.MemWrEn  = mem_wr;
  assign bus.LoadInst = load_inst;
  assign bus.Stall    = stall;
  assign bus.Busy     = busy_q;
  assign bus.Ack      = ack_q;

endmodule
